m_msg_scroller: RTL and testbench
=================================

# m_msg_scroller

Sequential reader for the 16-entry, two-variant seven-segment message ROM. Drives the ROM address and variant select, registers the returned active-low segment pattern, and time-multiplexes it across a multi-digit common-anode display, advancing a scroll offset so the message marches leftward. Sits between the message ROM and the board's segment/anode pins.

## Interface
- DIGITS, 4: number of display digits (1–8)
- SCAN_CYCLES, 50000: clock cycles per digit slot (≥2)
- STEP_CYCLES, 25000000: clock cycles per scroll step (≥1)
- clk  in  1  system clock, single domain
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable; low blanks display and holds offset
- variant_in  in  1  message select (0 = Hello, 1 = Goodbye)
- rom_variant  out  1  variant to ROM, registered
- rom_adr  out  4  ROM address, combinational from internal registers
- rom_dat  in  8  ROM data, combinational response to rom_adr/rom_variant
- seg  out  8  segment pattern, active-low, bit 7 = dp, registered
- an  out  DIGITS  digit enables, active-low, registered; an[DIGITS-1] = leftmost

## Operation
- State machine: IDLE, RUN. IDLE→RUN when en=1; RUN→IDLE when en=0; rst forces IDLE.
- IDLE: scan_cnt, dig, step_cnt cleared; offset and rom_variant held; seg/an loaded with 8'hFF / all ones.
- RUN: scan_cnt counts 0..SCAN_CYCLES-1, wraps; at terminal, dig increments 0..DIGITS-1, wraps. step_cnt counts 0..STEP_CYCLES-1; at terminal, offset increments mod 16 (15→0).
- rom_adr = (offset + dig) mod 16, 4-bit truncating add.
- Each RUN cycle: seg <= rom_dat; an <= all ones except bit DIGITS-1-dig low (dig 0 = leftmost shows offset character).
- Variant change: in RUN, if variant_in ≠ rom_variant, next cycle rom_variant <= variant_in, offset <= 0, step_cnt <= 0, dig <= 0, scan_cnt <= 0. Takes priority over a same-cycle step terminal.
- Simultaneous scan and step terminal: both applied in same cycle; next rom_adr reflects both.
- rst mid-operation: all state returns to reset values next edge, regardless of en.

## Timing
- Reset values: seg=8'hFF, an=all ones, rom_variant=0, offset=0, dig=0, scan_cnt=0, step_cnt=0, state=IDLE; rom_adr=0.
- ROM path combinational; seg/an lag (dig, offset) by exactly one clock.
- First lit output: en sampled high at edge N → state RUN after N; seg/an show dig 0 after edge N+1.
- en sampled low at edge M → state IDLE after M; seg/an blank after edge M+1.
- Variant change sampled at edge K → rom_variant/offset updated after K; new pattern on seg after K+1.
- Digit slot length SCAN_CYCLES; frame = DIGITS×SCAN_CYCLES; step period STEP_CYCLES counted only in RUN.

## Configuration
- SCROLLER_BLANK_EN defined: in RUN, while scan_cnt==0, an <= all ones (one-cycle ghosting blank at the start of every digit slot); visible slot = SCAN_CYCLES-1 cycles. seg still loads rom_dat.
- Undefined: an drives the selected digit for all SCAN_CYCLES cycles of its slot.

## Test plan
Parameters DIGITS=4, SCAN_CYCLES=4, STEP_CYCLES=32, macro undefined unless stated.
- Reset: rst high 3 cycles with en=1 → seg=8'hFF, an=4'hF, rom_adr=0, rom_variant=0 throughout and one cycle after release.
- Scan, variant 0, en=1: successive 4-cycle slots show seg 0x89/an 0111, 0x86/1011, 0xC7/1101, 0xC7/1110, repeat; with SCROLLER_BLANK_EN first cycle of each slot an=4'hF.
- Step and wrap: after 32 RUN cycles slot 0 shows 0x86, slot 3 0xA3; after 15×32 cycles digits show 0xFF,0x89,0x86,0xC7; after 16×32 back to 0x89 first.
- Variant toggle mid-slot at offset 3: next cycle rom_variant=1, rom_adr=0; digits then 0xC2,0xA3,0xA3,0xA1; coincident step terminal ignored.
- en drop mid-slot at offset 2: one cycle later seg=0xFF, an=4'hF; re-raise → resumes at dig 0 with offset 2 (first digit 0xC7).
- rst asserted mid-RUN at offset 5, dig 2 → next cycle offset 0, dig 0, outputs blank, state IDLE.

Source files
------------

// File: rtl/m_msg_scroller.sv
// m_msg_scroller
//   Reads a 16-entry, two-variant seven-segment message ROM and multiplexes
//   the returned patterns across a common-anode display. The scroll offset
//   advances every STEP_CYCLES run cycles, so the message marches leftward.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   en           run enable; low blanks the display and holds the offset
//   variant_in   message select (0 = Hello, 1 = Goodbye)
//   rom_variant  registered variant select to the ROM
//   rom_adr      ROM address = offset + dig (mod 16), combinational
//   rom_dat      ROM data, combinational response to rom_adr/rom_variant
//   seg          registered segment pattern, active-low, bit 7 = dp
//   an           registered digit enables, active-low, an[DIGITS-1] = leftmost
//
// Optional feature macro: SCROLLER_BLANK_EN
//   When defined, an is held all ones during the first cycle of every digit
//   slot to suppress ghosting between digits.

module m_msg_scroller #(
  parameter int DIGITS      = 4,
  parameter int SCAN_CYCLES = 50000,
  parameter int STEP_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              variant_in,
  output logic              rom_variant,
  output logic [3:0]        rom_adr,
  input  logic [7:0]        rom_dat,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);
  localparam logic [DIG_W-1:0]  DIG_ONE   = DIG_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [SCAN_W-1:0]   scan_cnt_r, scan_cnt_s;
  logic [STEP_W-1:0]   step_cnt_r, step_cnt_s;
  logic [DIG_W-1:0]    dig_r, dig_s;
  logic [3:0]          offset_r, offset_s;
  logic                variant_s;
  logic [7:0]          seg_s;
  logic [DIGITS-1:0]   an_s;
  logic [DIGITS-1:0]   an_sel_s;

  // ROM address: 4-bit truncating add wraps the message naturally.
  assign rom_adr = offset_r + 4'(dig_r);

  // Active-low one-hot enable for the current digit; dig 0 is the leftmost.
  always_comb begin
    an_sel_s = {DIGITS{1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      if (i == (DIGITS - 1 - int'(dig_r))) begin
        an_sel_s[i] = 1'b0;
      end else begin
        an_sel_s[i] = 1'b1;
      end
    end
  end

  // Next-state, counter and output-register logic.
  always_comb begin
    state_s    = state_r;
    scan_cnt_s = scan_cnt_r;
    step_cnt_s = step_cnt_r;
    dig_s      = dig_r;
    offset_s   = offset_r;
    variant_s  = rom_variant;
    seg_s      = 8'hFF;
    an_s       = {DIGITS{1'b1}};
    case (state_r)
      ST_IDLE: begin
        scan_cnt_s = {SCAN_W{1'b0}};
        step_cnt_s = {STEP_W{1'b0}};
        dig_s      = {DIG_W{1'b0}};
        if (en) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        seg_s = rom_dat;
`ifdef SCROLLER_BLANK_EN
        if (scan_cnt_r == {SCAN_W{1'b0}}) begin
          an_s = {DIGITS{1'b1}};
        end else begin
          an_s = an_sel_s;
        end
`else
        an_s = an_sel_s;
`endif
        if (!en) begin
          // Leaving RUN: offset is held, the scan restarts at dig 0 later.
          state_s    = ST_IDLE;
          scan_cnt_s = {SCAN_W{1'b0}};
          step_cnt_s = {STEP_W{1'b0}};
          dig_s      = {DIG_W{1'b0}};
        end else if (variant_in != rom_variant) begin
          // New message restarts from its first character; this wins over
          // any step terminal landing in the same cycle.
          variant_s  = variant_in;
          offset_s   = 4'd0;
          scan_cnt_s = {SCAN_W{1'b0}};
          step_cnt_s = {STEP_W{1'b0}};
          dig_s      = {DIG_W{1'b0}};
        end else begin
          if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_s = {SCAN_W{1'b0}};
            if (dig_r == DIG_LAST) begin
              dig_s = {DIG_W{1'b0}};
            end else begin
              dig_s = dig_r + DIG_ONE;
            end
          end else begin
            scan_cnt_s = scan_cnt_r + SCAN_ONE;
          end
          if (step_cnt_r == STEP_LAST) begin
            step_cnt_s = {STEP_W{1'b0}};
            offset_s   = offset_r + 4'd1;
          end else begin
            step_cnt_s = step_cnt_r + STEP_ONE;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      scan_cnt_r  <= {SCAN_W{1'b0}};
      step_cnt_r  <= {STEP_W{1'b0}};
      dig_r       <= {DIG_W{1'b0}};
      offset_r    <= 4'd0;
      rom_variant <= 1'b0;
      seg         <= 8'hFF;
      an          <= {DIGITS{1'b1}};
    end else begin
      state_r     <= state_s;
      scan_cnt_r  <= scan_cnt_s;
      step_cnt_r  <= step_cnt_s;
      dig_r       <= dig_s;
      offset_r    <= offset_s;
      rom_variant <= variant_s;
      seg         <= seg_s;
      an          <= an_s;
    end
  end

endmodule

// File: tb/tb_m_msg_scroller.sv
// Testbench for m_msg_scroller: directed vector table, hand-written corner
// sequences and randomized stimulus, all checked against a time-based model.
module tb_m_msg_scroller;

  localparam int DIG  = 4;
  localparam int SCAN = 4;
  localparam int STEP = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       variant_in = 1'b0;
  logic       rom_variant;
  logic [3:0] rom_adr;
  logic [7:0] rom_dat;
  logic [7:0] seg;
  logic [3:0] an;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: offset = base + elapsed/STEP, dig = elapsed/SCAN.
  bit m_run = 1'b0;
  int m_base = 0;
  int m_t = 0;
  bit m_var = 1'b0;

  m_msg_scroller #(.DIGITS(DIG), .SCAN_CYCLES(SCAN), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .rst(rst), .en(en), .variant_in(variant_in),
    .rom_variant(rom_variant), .rom_adr(rom_adr), .rom_dat(rom_dat),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic v, input logic [3:0] a);
    logic [7:0] d;
    d = 8'hFF;
    if (!v) begin
      case (a)
        4'd0: d = 8'h89; 4'd1: d = 8'h86; 4'd2: d = 8'hC7;
        4'd3: d = 8'hC7; 4'd4: d = 8'hA3; default: d = 8'hFF;
      endcase
    end else begin
      case (a)
        4'd0: d = 8'hC2; 4'd1: d = 8'hA3; 4'd2: d = 8'hA3; 4'd3: d = 8'hA1;
        4'd4: d = 8'h83; 4'd5: d = 8'h91; 4'd6: d = 8'h86; default: d = 8'hFF;
      endcase
    end
    return d;
  endfunction

  assign rom_dat = rom_fn(rom_variant, rom_adr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input bit r, input bit e, input bit v);
    logic [7:0] xs;
    logic [3:0] xa;
    int off;
    int dg;
    int xadr;
    rst = r; en = e; variant_in = v;
    xs = 8'hFF; xa = 4'hF;
    if (r) begin
      m_run = 1'b0; m_base = 0; m_t = 0; m_var = 1'b0;
    end else if (!m_run) begin
      if (e) begin m_run = 1'b1; m_t = 0; end
    end else begin
      off = (m_base + m_t / STEP) % 16;
      dg  = (m_t / SCAN) % DIG;
      xs  = rom_fn(m_var, 4'((off + dg) % 16));
      xa  = ~(4'b0001 << (DIG - 1 - dg));
`ifdef SCROLLER_BLANK_EN
      if (m_t % SCAN == 0) xa = 4'hF;
`endif
      if (!e) begin
        m_base = off; m_t = 0; m_run = 1'b0;
      end else if (v != m_var) begin
        m_var = v; m_base = 0; m_t = 0;
      end else begin
        m_t++;
      end
    end
    if (m_run) xadr = (m_base + m_t / STEP + (m_t / SCAN) % DIG) % 16;
    else       xadr = m_base;
    @(posedge clk);
    #1;
    chk("model_seg", 32'(seg), 32'(xs));
    chk("model_an", 32'(an), 32'(xa));
    chk("model_rom_adr", 32'(rom_adr), 32'(xadr));
    chk("model_rom_variant", 32'(rom_variant), 32'(m_var));
  endtask

  task automatic run_until(input int tgt, input bit v);
    while (m_t < tgt) cycle(1'b0, 1'b1, v);
  endtask

  typedef struct {
    bit         r;
    bit         e;
    bit         v;
    logic [7:0] seg;
    logic [3:0] an;
  } vec_t;

  vec_t vecs[20];
  logic [7:0] v0_seg[4];
  logic [3:0] v0_an[4];
  logic [7:0] v1_seg[4];

  initial begin
    bit rv;
    bit ev;
    bit vv;
    v0_seg[0] = 8'h89; v0_seg[1] = 8'h86; v0_seg[2] = 8'hC7; v0_seg[3] = 8'hC7;
    v0_an[0] = 4'b0111; v0_an[1] = 4'b1011; v0_an[2] = 4'b1101; v0_an[3] = 4'b1110;
    v1_seg[0] = 8'hC2; v1_seg[1] = 8'hA3; v1_seg[2] = 8'hA3; v1_seg[3] = 8'hA1;
    for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 8'hFF, 4'hF};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'hFF, 4'hF};
    for (int k = 0; k < 16; k++) begin
      vecs[4 + k] = '{1'b0, 1'b1, 1'b0, v0_seg[k / 4], v0_an[k / 4]};
`ifdef SCROLLER_BLANK_EN
      if (k % 4 == 0) vecs[4 + k].an = 4'hF;
`endif
    end

    // Reset and first frame from the vector table.
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].r, vecs[i].e, vecs[i].v);
      chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].seg));
      chk($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].an));
      if (i < 4) begin
        chk($sformatf("vec%0d_rom_adr", i), 32'(rom_adr), 32'd0);
        chk($sformatf("vec%0d_rom_variant", i), 32'(rom_variant), 32'd0);
      end
    end

    // Step and wrap of the scroll offset.
    run_until(32, 1'b0);  cycle(1'b0, 1'b1, 1'b0); chk("step1_dig0", 32'(seg), 32'h86);
    run_until(44, 1'b0);  cycle(1'b0, 1'b1, 1'b0); chk("step1_dig3", 32'(seg), 32'hA3);
    run_until(480, 1'b0); cycle(1'b0, 1'b1, 1'b0); chk("off15_dig0", 32'(seg), 32'hFF);
    run_until(484, 1'b0); cycle(1'b0, 1'b1, 1'b0); chk("off15_dig1", 32'(seg), 32'h89);
    run_until(488, 1'b0); cycle(1'b0, 1'b1, 1'b0); chk("off15_dig2", 32'(seg), 32'h86);
    run_until(492, 1'b0); cycle(1'b0, 1'b1, 1'b0); chk("off15_dig3", 32'(seg), 32'hC7);
    run_until(512, 1'b0); cycle(1'b0, 1'b1, 1'b0); chk("wrap_dig0", 32'(seg), 32'h89);

    // en drop mid-slot at offset 2, then resume.
    run_until(578, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("endrop_seg", 32'(seg), 32'hFF);
    chk("endrop_an", 32'(an), 32'hF);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("reen_blank", 32'(seg), 32'hFF);
    cycle(1'b0, 1'b1, 1'b0);
    chk("reen_first", 32'(seg), 32'hC7);

    // Variant toggle at offset 3 coinciding with step and scan terminals.
    run_until(63, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("toggle_variant", 32'(rom_variant), 32'd1);
    chk("toggle_adr", 32'(rom_adr), 32'd0);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b1, 1'b1);
      if (k % 4 == 0) chk($sformatf("v1_dig%0d", k / 4), 32'(seg), 32'(v1_seg[k / 4]));
    end

    // Reset mid-RUN at offset 5, dig 2.
    run_until(168, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_adr", 32'(rom_adr), 32'd0);
    chk("rst_variant", 32'(rom_variant), 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("rst_idle_blank", 32'(seg), 32'hFF);

    // Randomized stimulus against the model.
    vv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 299) == 0);
      ev = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 149) == 0) vv = ~vv;
      cycle(rv, ev, vv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
